// File: rtl/por_seq_pkg.sv
// Shared types and width helpers for the power-on reset sequencer.
package por_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_DEBOUNCE,
    ST_WAIT,
    ST_DONE
  } por_state_e;

  function automatic int cnt_width(input int debounce_cycles, input int stage_delay);
    int m;
    m = (debounce_cycles > stage_delay) ? debounce_cycles : stage_delay;
    return $clog2(m + 1);
  endfunction

  function automatic int stage_width(input int num_domains);
    return $clog2(num_domains + 1);
  endfunction

endpackage

// File: rtl/por_sync.sv
// Multi-flop synchroniser for the raw POR_N from the IO-ring POR cell.
module por_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic por_n_i,
  output logic por_s_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], por_n_i};
  end

  assign por_s_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/por_reset_sequencer.sv
// Debounces the synchronised POR and releases domain resets in order 0..N-1.
//   state    | meaning
//   HOLD     | all domains in reset, waiting for POR high and no restart
//   DEBOUNCE | counting consecutive POR-high cycles
//   WAIT     | gap timer before releasing domain idx (held by SW_HOLD_I)
//   DONE     | every domain released
module por_reset_sequencer
  import por_seq_pkg::*;
#(
  parameter int NUM_DOMAINS     = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STAGE_DELAY     = 8
) (
  input  logic                                CLK_I,
  input  logic                                RST_I,
  input  logic                                POR_N_I,
  input  logic                                SW_RESET_I,
  input  logic [NUM_DOMAINS-1:0]              SW_HOLD_I,
  output logic [NUM_DOMAINS-1:0]              RST_N_O,
  output logic [stage_width(NUM_DOMAINS)-1:0] STAGE_O,
  output logic                                DONE_O
);

  localparam int CW  = cnt_width(DEBOUNCE_CYCLES, STAGE_DELAY);
  localparam int STW = stage_width(NUM_DOMAINS);
  localparam logic [CW-1:0]  DEB_TC   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  STG_TC   = CW'(STAGE_DELAY - 1);
  localparam logic [STW-1:0] LAST_IDX = STW'(NUM_DOMAINS - 1);

  por_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [STW-1:0]         idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
  logic [STW-1:0]         stage_q, stage_d;
  logic                   done_q, done_d;
  logic                   por_s, abort, hold_cur, release_go;

  por_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (CLK_I),
    .rst_i  (RST_I),
    .por_n_i(POR_N_I),
    .por_s_o(por_s)
  );

  assign abort = !por_s || SW_RESET_I;

  always_comb begin
    hold_cur = 1'b0;
    for (int i = 0; i < NUM_DOMAINS; i++)
      if (idx_q == STW'(i)) hold_cur = SW_HOLD_I[i];
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      stage_q <= stage_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    release_go = 1'b0;
    if (abort) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          state_d = ST_DEBOUNCE;
          cnt_d   = '0;
        end
        ST_DEBOUNCE: begin
          if (cnt_q == DEB_TC) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT: begin
          // Timer parks at terminal count while the current domain is held.
          if (cnt_q != STG_TC) begin
            cnt_d = cnt_q + 1'b1;
          end else if (!hold_cur) begin
            release_go = 1'b1;
            cnt_d      = '0;
            if (idx_q == LAST_IDX) state_d = ST_DONE;
            else                   idx_d   = idx_q + 1'b1;
          end
        end
        ST_DONE: ;
        default: state_d = ST_HOLD;
      endcase
    end
  end

  always_comb begin
    rst_n_d = rst_n_q;
    stage_d = stage_q;
    done_d  = done_q;
    if (abort) begin
      rst_n_d = '0;
      stage_d = '0;
      done_d  = 1'b0;
    end else if (release_go) begin
      for (int i = 0; i < NUM_DOMAINS; i++)
        if (idx_q == STW'(i)) rst_n_d[i] = 1'b1;
      stage_d = idx_q + 1'b1;
      done_d  = (idx_q == LAST_IDX);
    end
  end

  assign RST_N_O = rst_n_q;
  assign STAGE_O = stage_q;
  assign DONE_O  = done_q;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Scoreboard bench: driver pushes model expectations, monitor compares after each edge.
module tb_por_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst, por_n, sw_reset;
  logic [3:0] sw_hold;
  logic [3:0] rn;
  logic [2:0] st;
  logic       dn;
  logic [0:0] rn1;
  logic [0:0] st1;
  logic       dn1;

  always #5 clk = ~clk;

  por_reset_sequencer u_dut (
    .CLK_I(clk), .RST_I(rst), .POR_N_I(por_n), .SW_RESET_I(sw_reset),
    .SW_HOLD_I(sw_hold), .RST_N_O(rn), .STAGE_O(st), .DONE_O(dn)
  );

  por_reset_sequencer #(
    .NUM_DOMAINS(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .STAGE_DELAY(1)
  ) u_dut1 (
    .CLK_I(clk), .RST_I(rst), .POR_N_I(por_n), .SW_RESET_I(sw_reset),
    .SW_HOLD_I(sw_hold[0]), .RST_N_O(rn1), .STAGE_O(st1), .DONE_O(dn1)
  );

  // Model: 'run' counts consecutive non-abort edges; a domain is due
  // 1+D+S runs after the restart, then S runs after the previous release.
  typedef struct {
    int         run;
    int         n;
    int         due;
    logic [7:0] hist;
  } mst_t;

  typedef struct {
    logic [3:0] rn;
    int         st;
    logic       dn;
    logic       rn1;
    int         st1;
    logic       dn1;
  } exp_t;

  mst_t m0, m1;
  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic mst_t step(input mst_t s, input int nd, input int db, input int sd,
                                input bit r, input bit por, input bit swr, input logic [3:0] hold);
    mst_t o;
    bit   por_s;
    o = s;
    if (r) begin
      o.run = 0; o.n = 0; o.due = 1 + db + sd; o.hist = '0;
      return o;
    end
    por_s  = s.hist[1];
    o.hist = {s.hist[6:0], por};
    if (!por_s || swr) begin
      o.run = 0; o.n = 0; o.due = 1 + db + sd;
    end else begin
      o.run++;
      if (o.n < nd && o.run >= o.due && !hold[o.n]) begin
        o.n++;
        o.due = o.run + sd;
      end
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
  endtask

  task automatic cycle(input bit r, input bit p, input bit swr, input logic [3:0] h);
    exp_t e;
    @(negedge clk);
    rst = r; por_n = p; sw_reset = swr; sw_hold = h;
    m0 = step(m0, 4, 16, 8, r, p, swr, h);
    m1 = step(m1, 1, 1, 1, r, p, swr, h);
    e.rn  = 4'((1 << m0.n) - 1);
    e.st  = m0.n;
    e.dn  = (m0.n == 4);
    e.rn1 = (m1.n == 1);
    e.st1 = m1.n;
    e.dn1 = (m1.n == 1);
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rst_n",     32'(rn),  32'(e.rn));
        chk("stage",     32'(st),  32'(e.st));
        chk("done",      32'(dn),  32'(e.dn));
        chk("rst_n_n1",  32'(rn1), 32'(e.rn1));
        chk("stage_n1",  32'(st1), 32'(e.st1));
        chk("done_n1",   32'(dn1), 32'(e.dn1));
        chk("thermometer", 32'((({1'b0, rn} & ({1'b0, rn} + 5'd1)) == 5'd0)), 32'd1);
        chk("popcount",  32'($countones(rn)), 32'(st));
      end
    end
  end

  initial begin : driver
    logic [3:0] h;
    int         k;
    rst = 1'b1; por_n = 1'b0; sw_reset = 1'b0; sw_hold = '0;

    // full release sequence from reset
    repeat (3) cycle(1, 1, 0, 4'b0);
    repeat (60) cycle(0, 1, 0, 4'b0);

    // one-cycle POR glitch during debounce
    cycle(1, 1, 0, 4'b0);
    repeat (2 + 10) cycle(0, 1, 0, 4'b0);
    cycle(0, 0, 0, 4'b0);
    repeat (45) cycle(0, 1, 0, 4'b0);

    // POR drop once two domains are out
    cycle(1, 1, 0, 4'b0);
    k = 0;
    while (m0.n < 2 && k < 200) begin cycle(0, 1, 0, 4'b0); k++; end
    repeat ($urandom_range(1, 4)) cycle(0, 0, 0, 4'b0);
    repeat (60) cycle(0, 1, 0, 4'b0);

    // software hold on domain 2
    cycle(1, 1, 0, 4'b0);
    k = 0;
    while (m0.n < 2 && k < 200) begin cycle(0, 1, 0, 4'b0100); k++; end
    repeat (28) cycle(0, 1, 0, 4'b0100);
    repeat (20) cycle(0, 1, 0, 4'b0);

    // one-cycle software restart in DONE
    cycle(0, 1, 1, 4'b0);
    repeat (45) cycle(0, 1, 0, 4'b0);

    // randomized soak
    h = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) h = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) != 0),
            ($urandom_range(0, 149) == 0), h);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
